digit_store: RTL and testbench

- Parametrised multi-digit register file that succeeds the fixed 8×4-bit nibble demux.
- Holds NUM_DIGITS digits of DIGIT_W bits in a configurable radix.
- Accepts per-digit operations through a valid/ready handshake: load, increment, decrement, clear.
- Increment and decrement ripple the carry or borrow into higher digits, one digit per cycle.
- Sits between the switch/button front end and the seven-segment display scanner.

---
 rtl/digit_store_pkg.sv | 22 ++
 rtl/digit_step.sv | 37 +++
 rtl/digit_store.sv | 178 +++++++++++++++++
 tb/tb_digit_store.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/digit_store_pkg.sv
// rtl/digit_store_pkg.sv - op encodings, FSM states and digit helpers for digit_store
package digit_store_pkg;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_INC   = 3'b001;
    localparam logic [2:0] OP_DEC   = 3'b010;
    localparam logic [2:0] OP_CLEAR = 3'b011;
    localparam logic [2:0] OP_SHIFT = 3'b100;

    localparam logic DIR_INC = 1'b0;
    localparam logic DIR_DEC = 1'b1;

    typedef enum logic {
        ST_IDLE,
        ST_RIPPLE
    } state_e;

    function automatic int unsigned sat_digit(input int unsigned d, input int unsigned radix);
        return (d >= radix) ? radix - 1 : d;
    endfunction

endpackage

// File: rtl/digit_step.sv
// rtl/digit_step.sv - combinational single-digit increment/decrement with carry/borrow out
module digit_step
    import digit_store_pkg::*;
#(
    parameter int DIGIT_W = 4,
    parameter int RADIX   = 16
) (
    input  logic [DIGIT_W-1:0] d,
    input  logic               dir,
    output logic [DIGIT_W-1:0] q,
    output logic               carry
);

    localparam logic [DIGIT_W-1:0] TOP = DIGIT_W'(RADIX - 1);

    always_comb begin
        q     = d;
        carry = 1'b0;
        if (dir == DIR_INC) begin
            // out-of-radix digits behave as the top digit value and wrap
            if (d >= TOP) begin
                q     = '0;
                carry = 1'b1;
            end else begin
                q = d + DIGIT_W'(1);
            end
        end else begin
            if (d == '0) begin
                q     = TOP;
                carry = 1'b1;
            end else begin
                q = d - DIGIT_W'(1);
            end
        end
    end

endmodule

// File: rtl/digit_store.sv
// rtl/digit_store.sv - multi-digit radix register file with rippling inc/dec; SHIFT via DIGIT_STORE_SHIFT_EN
module digit_store
    import digit_store_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int DIGIT_W    = 4,
    parameter int RADIX      = 16,
    parameter int SEL_W      = $clog2(NUM_DIGITS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          op_valid,
    output logic                          op_ready,
    input  logic [2:0]                    op,
    input  logic [SEL_W-1:0]              sel,
    input  logic [DIGIT_W-1:0]            din,
    output logic [NUM_DIGITS*DIGIT_W-1:0] store,
    output logic                          done,
    output logic                          ovf,
    output logic                          err
);

    typedef logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digits_t;

    localparam logic [SEL_W-1:0] TOP_IDX = SEL_W'(NUM_DIGITS - 1);
    localparam logic [31:0]      ND      = NUM_DIGITS;

    digits_t            digits_q, digits_d;
    state_e             state_q, state_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic               dir_q, dir_d;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;
    logic               err_q, err_d;

    logic               accept;
    logic               sel_ok;
    logic [SEL_W-1:0]   cur_idx;
    logic               step_dir;
    logic [DIGIT_W-1:0] step_in;
    logic [DIGIT_W-1:0] step_out;
    logic               step_carry;
    logic [DIGIT_W-1:0] din_sat;
    logic               wr_en;
    logic [DIGIT_W-1:0] wr_data;

    assign op_ready = (state_q == ST_IDLE) && !rst;
    assign accept   = op_valid && op_ready;
    assign sel_ok   = (32'(sel) < ND);
    assign din_sat  = DIGIT_W'(sat_digit(32'(din), RADIX));
    assign store    = digits_q;
    assign done     = done_q;
    assign ovf      = ovf_q;
    assign err      = err_q;

    // one stepper serves both the acceptance digit and the ripple digit
    always_comb begin
        cur_idx  = idx_q;
        step_dir = dir_q;
        step_in  = '0;
        if (state_q == ST_IDLE) begin
            cur_idx  = sel;
            step_dir = (op == OP_DEC) ? DIR_DEC : DIR_INC;
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (cur_idx == SEL_W'(i)) step_in = digits_q[i];
        end
    end

    digit_step #(
        .DIGIT_W (DIGIT_W),
        .RADIX   (RADIX)
    ) u_step (
        .d     (step_in),
        .dir   (step_dir),
        .q     (step_out),
        .carry (step_carry)
    );

    always_comb begin
        digits_d = digits_q;
        state_d  = state_q;
        idx_d    = idx_q;
        dir_d    = dir_q;
        done_d   = 1'b0;
        ovf_d    = 1'b0;
        err_d    = 1'b0;
        wr_en    = 1'b0;
        wr_data  = step_out;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (op)
                        OP_LOAD: begin
                            if (sel_ok) begin
                                wr_en   = 1'b1;
                                wr_data = din_sat;
                                done_d  = 1'b1;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        OP_INC, OP_DEC: begin
                            if (sel_ok) begin
                                wr_en = 1'b1;
                                if (!step_carry) begin
                                    done_d = 1'b1;
                                end else if (sel == TOP_IDX) begin
                                    done_d = 1'b1;
                                    ovf_d  = 1'b1;
                                end else begin
                                    state_d = ST_RIPPLE;
                                    idx_d   = sel + SEL_W'(1);
                                    dir_d   = step_dir;
                                end
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        OP_CLEAR: begin
                            digits_d = '0;
                            done_d   = 1'b1;
                        end
`ifdef DIGIT_STORE_SHIFT_EN
                        OP_SHIFT: begin
                            digits_d = {digits_q[NUM_DIGITS-2:0], din_sat};
                            done_d   = 1'b1;
                        end
`endif
                        default: err_d = 1'b1;
                    endcase
                end
            end
            ST_RIPPLE: begin
                wr_en = 1'b1;
                if (!step_carry) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (idx_q == TOP_IDX) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    ovf_d   = 1'b1;
                end else begin
                    idx_d = idx_q + SEL_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (wr_en) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (cur_idx == SEL_W'(i)) digits_d[i] = wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digits_q <= '0;
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            dir_q    <= DIR_INC;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            digits_q <= digits_d;
            state_q  <= state_d;
            idx_q    <= idx_d;
            dir_q    <= dir_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_digit_store.sv
// tb/tb_digit_store.sv - randomized bench for digit_store against a numeric radix model (BCD and hex units)
module tb_digit_store;

`ifdef DIGIT_STORE_SHIFT_EN
    localparam bit SHIFT_EN = 1'b1;
`else
    localparam bit SHIFT_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        op_valid   [2];
    logic [2:0]  op_i       [2];
    logic [3:0]  sel_i      [2];
    logic [3:0]  din_i      [2];
    logic        op_ready_o [2];
    logic        done_o     [2];
    logic        ovf_o      [2];
    logic        err_o      [2];
    logic [31:0] store_o    [2];

    longint      val_m   [2];
    int          radix_m [2] = '{10, 16};
    int          n_cmp = 0;
    int          n_bad = 0;

    digit_store #(.NUM_DIGITS(8), .DIGIT_W(4), .RADIX(10), .SEL_W(4)) u_bcd (
        .clk(clk), .rst(rst), .op_valid(op_valid[0]), .op_ready(op_ready_o[0]),
        .op(op_i[0]), .sel(sel_i[0]), .din(din_i[0]), .store(store_o[0]),
        .done(done_o[0]), .ovf(ovf_o[0]), .err(err_o[0])
    );

    digit_store #(.NUM_DIGITS(8), .DIGIT_W(4), .RADIX(16), .SEL_W(4)) u_hex (
        .clk(clk), .rst(rst), .op_valid(op_valid[1]), .op_ready(op_ready_o[1]),
        .op(op_i[1]), .sel(sel_i[1]), .din(din_i[1]), .store(store_o[1]),
        .done(done_o[1]), .ovf(ovf_o[1]), .err(err_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic longint rpow(input longint r, input int e);
        longint p = 1;
        for (int i = 0; i < e; i++) p = p * r;
        return p;
    endfunction

    function automatic longint digit_at(input longint v, input longint r, input int i);
        return (v / rpow(r, i)) % r;
    endfunction

    function automatic logic [31:0] to_store(input longint v, input longint r);
        logic [31:0] s = '0;
        for (int i = 0; i < 8; i++) begin
            s[i*4 +: 4] = 4'(v % r);
            v = v / r;
        end
        return s;
    endfunction

    task automatic run_op(input int u, input logic [2:0] o, input logic [3:0] s, input logic [3:0] d);
        longint r, span, p, nv, dsat;
        int     si, k, lat_e, lat, n;
        bit     err_e, ovf_e;
        r     = radix_m[u];
        span  = rpow(r, 8);
        si    = int'(s);
        nv    = val_m[u];
        dsat  = (longint'(d) >= r) ? r - 1 : longint'(d);
        err_e = 1'b0;
        ovf_e = 1'b0;
        lat_e = 1;
        if (o > 3'd4 || (o == 3'd4 && !SHIFT_EN) || (o <= 3'd2 && si >= 8)) begin
            err_e = 1'b1;
        end else begin
            p = (si < 8) ? rpow(r, si) : 0;
            case (o)
                3'd0: nv = val_m[u] - digit_at(val_m[u], r, si) * p + dsat * p;
                3'd1: begin
                    k = si;
                    while (k < 8 && digit_at(val_m[u], r, k) == r - 1) k++;
                    nv = val_m[u] + p;
                    if (nv >= span) begin
                        nv    = nv - span;
                        ovf_e = 1'b1;
                        lat_e = k - si;
                    end else begin
                        lat_e = k - si + 1;
                    end
                end
                3'd2: begin
                    k = si;
                    while (k < 8 && digit_at(val_m[u], r, k) == 0) k++;
                    nv = val_m[u] - p;
                    if (nv < 0) begin
                        nv    = nv + span;
                        ovf_e = 1'b1;
                        lat_e = k - si;
                    end else begin
                        lat_e = k - si + 1;
                    end
                end
                3'd3: nv = 0;
                default: nv = (val_m[u] * r) % span + dsat;
            endcase
        end

        @(negedge clk);
        op_valid[u] = 1'b1;
        op_i[u]     = o;
        sel_i[u]    = s;
        din_i[u]    = d;
        n = 0;
        while (!op_ready_o[u] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", 64'(n < 50), 64'(1));
        @(posedge clk);
        #1;
        op_valid[u] = 1'b0;
        lat = 1;
        while (!done_o[u] && !err_o[u] && lat < 20) begin
            check("busy_ready", 64'(op_ready_o[u]), 64'(0));
            @(posedge clk);
            #1;
            lat++;
        end
        val_m[u] = nv;
        check("err", 64'(err_o[u]), 64'(err_e));
        check("done", 64'(done_o[u]), 64'(!err_e));
        check("latency", 64'(lat), 64'(lat_e));
        check("ovf", 64'(ovf_o[u]), 64'(ovf_e));
        check("store", 64'(store_o[u]), 64'(to_store(nv, r)));
    endtask

    task automatic load_all(input int u, input logic [31:0] s);
        for (int i = 0; i < 8; i++) run_op(u, 3'd0, 4'(i), s[i*4 +: 4]);
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            op_valid[u] = 1'b1;
            op_i[u]     = 3'd0;
            sel_i[u]    = 4'd1;
            din_i[u]    = 4'd5;
            val_m[u]    = 0;
        end
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            for (int u = 0; u < 2; u++) begin
                check("rst_ready", 64'(op_ready_o[u]), 64'(0));
                check("rst_store", 64'(store_o[u]), 64'(0));
                check("rst_done", 64'(done_o[u] | err_o[u] | ovf_o[u]), 64'(0));
            end
        end
        @(negedge clk);
        rst = 1'b0;
        op_valid[0] = 1'b0;
        op_valid[1] = 1'b0;
        #1;
        check("post_rst_ready0", 64'(op_ready_o[0]), 64'(1));
        check("post_rst_ready1", 64'(op_ready_o[1]), 64'(1));

        load_all(0, 32'h00000999);
        run_op(0, 3'd1, 4'd0, 4'd0);
        check("bcd_inc_999", 64'(store_o[0]), 64'h00001000);

        load_all(1, 32'hFFFFFFFF);
        run_op(1, 3'd1, 4'd0, 4'd0);
        check("hex_inc_wrap", 64'(store_o[1]), 64'h0);

        load_all(0, 32'h00000100);
        run_op(0, 3'd2, 4'd0, 4'd0);
        check("bcd_dec_100", 64'(store_o[0]), 64'h00000099);
        run_op(0, 3'd0, 4'd7, 4'hC);
        check("bcd_load_sat", 64'(store_o[0]), 64'h90000099);

        load_all(1, 32'h12345678);
        run_op(1, 3'd0, 4'd9, 4'd3);
        check("sel_oob_keep", 64'(store_o[1]), 64'h12345678);
        run_op(1, 3'd4, 4'd0, 4'hA);
`ifdef DIGIT_STORE_SHIFT_EN
        check("shift", 64'(store_o[1]), 64'h2345678A);
`else
        check("op100_keep", 64'(store_o[1]), 64'h12345678);
`endif

        // reset on the second ripple edge of a three-digit carry
        load_all(0, 32'h00000999);
        @(negedge clk);
        op_valid[0] = 1'b1;
        op_i[0]     = 3'd1;
        sel_i[0]    = 4'd0;
        @(posedge clk);
        #1;
        op_valid[0] = 1'b0;
        @(posedge clk);
        #1;
        check("mid_ripple_busy", 64'(op_ready_o[0]), 64'(0));
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_store", 64'(store_o[0]), 64'h0);
        check("mid_rst_done", 64'(done_o[0]), 64'(0));
        rst = 1'b0;
        val_m[0] = 0;
        val_m[1] = 0;
        #1;
        check("mid_rst_idle", 64'(op_ready_o[0]), 64'(1));
        @(posedge clk);
        #1;
        check("mid_rst_no_done", 64'(done_o[0]), 64'(0));

        for (int t = 0; t < 300; t++) begin
            int          u, pick;
            logic [2:0]  o;
            logic [3:0]  d;
            u    = t % 2;
            pick = $urandom_range(0, 15);
            d    = 4'($urandom_range(0, 15));
            if (pick < 4)       begin o = 3'd0; if (pick < 2) d = 4'hF; end
            else if (pick < 8)  o = 3'd1;
            else if (pick < 11) o = 3'd2;
            else if (pick == 11) o = 3'd3;
            else if (pick == 12) o = 3'd4;
            else                o = 3'($urandom_range(4, 7));
            run_op(u, o, 4'($urandom_range(0, 9)), d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
